ring_monitor: RTL

Receive-side checker for a one-hot ring counter. Each enabled cycle it samples an N-bit ring vector and confirms the vector is one-hot and has advanced by exactly one position since the last sample. It reports the binary index of the hot bit and counts completed laps. Any break in the sequence raises a sticky error. It sits downstream of a ring counter, for example on the LED-driving vector, as a self-test and decode stage.

---
 rtl/ring_monitor.sv | 115 +++++++++++
 1 files changed

// File: rtl/ring_monitor.sv
// One-hot ring counter checker: confirms each enabled sample is one-hot and one step ahead
// of the last, decodes the hot index, counts laps and latches a sticky error on any break.
module ring_monitor #(
   parameter int unsigned N    = 3,
   parameter int unsigned LAPW = 8,
   localparam int unsigned IW  = (N > 1) ? $clog2(N) : 1
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            CE,
   input  logic            CLR,
   input  logic [N-1:0]    I,
   output logic [IW-1:0]   IDX,
   output logic            VALID,
   output logic [LAPW-1:0] LAP,
   output logic            ERR
);

   typedef enum logic [1:0] {StAcq, StTrack, StFault} state_e;

   state_e          state_q, state_d;
   logic [N-1:0]    prev_q, prev_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            valid_q, valid_d;
   logic [LAPW-1:0] lap_q, lap_d;
   logic            err_q, err_d;

   logic            is_onehot;
   logic [IW-1:0]   hot_idx;
   logic [N-1:0]    prev_rot;
   logic [IW-1:0]   idx_inc;

   // Power-of-two test: exactly one bit set when nonzero and clearing the lowest set bit gives zero.
   assign is_onehot = (I != '0) && ((I & (I - N'(1))) == '0);
   assign prev_rot  = {prev_q[N-2:0], prev_q[N-1]};
   assign idx_inc   = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);

   always_comb begin
      hot_idx = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (I[k]) hot_idx = IW'(k);
      end
   end

   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      lap_d   = lap_q;
      err_d   = err_q;
      if (CLR) begin
         state_d = StAcq;
         err_d   = 1'b0;
         lap_d   = '0;
         valid_d = 1'b0;
      end else if (CE) begin
         case (state_q)
            StAcq: begin
               if (is_onehot) begin
                  prev_d  = I;
                  idx_d   = hot_idx;
                  valid_d = 1'b1;
                  state_d = StTrack;
               end else begin
                  valid_d = 1'b0;
               end
            end
            StTrack: begin
               if (I == prev_rot) begin
                  prev_d = I;
                  idx_d  = idx_inc;
                  if (prev_q[N-1]) lap_d = lap_q + LAPW'(1);
               end else begin
                  err_d   = 1'b1;
                  valid_d = 1'b0;
                  state_d = StFault;
               end
            end
            StFault: begin
               valid_d = 1'b0;
               err_d   = 1'b1;
            end
            default: begin
               state_d = StAcq;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= StAcq;
         prev_q  <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         lap_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         lap_q   <= lap_d;
         err_q   <= err_d;
      end
   end

   assign IDX   = idx_q;
   assign VALID = valid_q;
   assign LAP   = lap_q;
   assign ERR   = err_q;

endmodule
